fetch_pc_decode: RTL and testbench

Front-end fetch/decode block of the SPARC-subset pipelined processor. It holds the architectural PC and nPC register pair and advances them through a +4 adder. It also decodes the 32-bit instruction in the ID stage into a 20-bit control-signal vector. That vector feeds the control-signal mux and the ID/EX pipeline register.

---
 rtl/fetch_pc_decode.sv | 185 ++++++++++++++++++
 tb/tb_fetch_pc_decode.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_decode.sv
// Fetch/decode front end: PC/nPC register pair with +4 adder, and a purely
// combinational decoder from the ID-stage instruction to a 20-bit control vector.
module fetch_pc_decode #(
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        le,
  input  logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] npc,
  output logic [31:0] npc_plus4,
  output logic [19:0] instr_signals
);

  // Major opcode, instr[31:30]
  localparam logic [1:0] OpFmt2  = 2'b00;
  localparam logic [1:0] OpCall  = 2'b01;
  localparam logic [1:0] OpArith = 2'b10;
  localparam logic [1:0] OpMem   = 2'b11;

  // Format-2 sub-opcode, instr[24:22]
  localparam logic [2:0] Op2Bicc  = 3'b010;
  localparam logic [2:0] Op2Sethi = 3'b100;

  // Format-3 sub-opcodes of interest, instr[24:19]
  localparam logic [5:0] Op3Sll  = 6'b100101;
  localparam logic [5:0] Op3Srl  = 6'b100110;
  localparam logic [5:0] Op3Sra  = 6'b100111;
  localparam logic [5:0] Op3Jmpl = 6'b111000;

  // ALU opcodes produced directly by the decoder
  localparam logic [3:0] AluAdd   = 4'b0000;
  localparam logic [3:0] AluSll   = 4'b1010;
  localparam logic [3:0] AluSrl   = 4'b1011;
  localparam logic [3:0] AluSra   = 4'b1101;
  localparam logic [3:0] AluPassB = 4'b1110;

  localparam logic [1:0] SizeWord = 2'b00;

  // ---------------------------------------------------------------------------
  // PC / nPC pair
  // ---------------------------------------------------------------------------
  logic [31:0] pc_q, pc_d;
  logic [31:0] npc_q, npc_d;
  logic [31:0] npc_inc;

  assign npc_inc = npc_q + 32'd4;

  always_comb begin
    pc_d  = pc_q;
    npc_d = npc_q;
    if (clr) begin
      pc_d  = RESET_PC;
      npc_d = RESET_PC + 32'd4;
    end else if (le) begin
      pc_d  = npc_q;
      npc_d = npc_inc;
    end
  end

  always_ff @(posedge clk) begin
    pc_q  <= pc_d;
    npc_q <= npc_d;
  end

  assign pc        = pc_q;
  assign npc       = npc_q;
  assign npc_plus4 = npc_inc;

  // ---------------------------------------------------------------------------
  // Instruction decode
  // ---------------------------------------------------------------------------
  logic [1:0] op;
  logic [2:0] op2;
  logic [5:0] op3;

  assign op  = instr[31:30];
  assign op2 = instr[24:22];
  assign op3 = instr[24:19];

  logic       dec_jmpl;
  logic       dec_call;
  logic       dec_load;
  logic       dec_rf_we;
  logic       dec_mem_se;
  logic       dec_mem_rw;
  logic       dec_mem_en;
  logic [1:0] dec_mem_size;
  logic       dec_cc_en;
  logic [3:0] dec_alu_op;
  logic       dec_store;
  logic       dec_branch;

  always_comb begin
    dec_jmpl     = 1'b0;
    dec_call     = 1'b0;
    dec_load     = 1'b0;
    dec_rf_we    = 1'b0;
    dec_mem_se   = 1'b0;
    dec_mem_rw   = 1'b0;
    dec_mem_en   = 1'b0;
    dec_mem_size = SizeWord;
    dec_cc_en    = 1'b0;
    dec_alu_op   = AluAdd;
    dec_store    = 1'b0;
    dec_branch   = 1'b0;

    unique case (op)
      OpCall: begin
        dec_call   = 1'b1;
        dec_rf_we  = 1'b1;
        dec_alu_op = AluAdd;
      end

      OpFmt2: begin
        // Anything other than sethi/Bicc (unimp, nop-like zero word) decodes to no-op.
        if (op2 == Op2Sethi) begin
          dec_rf_we  = 1'b1;
          dec_alu_op = AluPassB;
        end else if (op2 == Op2Bicc) begin
          dec_branch = 1'b1;
        end
      end

      OpArith: begin
        // Shifts and jmpl live in the op3[5]=1 half, so they must win over the generic rule.
        if (op3 == Op3Jmpl) begin
          dec_jmpl   = 1'b1;
          dec_rf_we  = 1'b1;
          dec_alu_op = AluAdd;
        end else if (op3 == Op3Sll) begin
          dec_rf_we  = 1'b1;
          dec_alu_op = AluSll;
        end else if (op3 == Op3Srl) begin
          dec_rf_we  = 1'b1;
          dec_alu_op = AluSrl;
        end else if (op3 == Op3Sra) begin
          dec_rf_we  = 1'b1;
          dec_alu_op = AluSra;
        end else if (!op3[5]) begin
          dec_rf_we  = 1'b1;
          dec_alu_op = op3[3:0];
          dec_cc_en  = op3[4];
        end
      end

      OpMem: begin
        dec_mem_en   = 1'b1;
        dec_alu_op   = AluAdd;
        dec_mem_size = (op3[1:0] == 2'b11) ? SizeWord : op3[1:0];
        if (op3[2]) begin
          dec_store  = 1'b1;
          dec_mem_rw = 1'b1;
        end else begin
          dec_load   = 1'b1;
          dec_rf_we  = 1'b1;
          dec_mem_se = op3[3];
        end
      end

      default: ;
    endcase
  end

  assign instr_signals = {
    dec_branch,    // [19]
    dec_store,     // [18]
    dec_alu_op,    // [17:14]
    instr[13],     // [13]
    instr[24],     // [12]
    instr[30],     // [11]
    instr[31],     // [10]
    dec_cc_en,     // [9]
    dec_mem_size,  // [8:7]
    dec_mem_en,    // [6]
    dec_mem_rw,    // [5]
    dec_mem_se,    // [4]
    dec_rf_we,     // [3]
    dec_load,      // [2]
    dec_call,      // [1]
    dec_jmpl       // [0]
  };

endmodule

// File: tb/tb_fetch_pc_decode.sv
// Scoreboard bench for fetch_pc_decode: stimulus pushes expectations from a
// behavioural model, a negedge monitor pops and compares.
module tb_fetch_pc_decode;

  localparam logic [31:0] WrapReset = 32'hFFFF_FFF8;

  logic        clk;
  logic        clr;
  logic        le;
  logic [31:0] instr;
  logic [31:0] pc, npc, npc_plus4;
  logic [19:0] instr_signals;
  logic [31:0] pc_w, npc_w, npc_plus4_w;
  logic [19:0] instr_signals_w;

  fetch_pc_decode #(.RESET_PC(32'd0)) dut (
    .clk          (clk),
    .clr          (clr),
    .le           (le),
    .instr        (instr),
    .pc           (pc),
    .npc          (npc),
    .npc_plus4    (npc_plus4),
    .instr_signals(instr_signals)
  );

  // Second instance near the top of the address space to exercise adder wrap.
  fetch_pc_decode #(.RESET_PC(WrapReset)) dut_w (
    .clk          (clk),
    .clr          (clr),
    .le           (le),
    .instr        (instr),
    .pc           (pc_w),
    .npc          (npc_w),
    .npc_plus4    (npc_plus4_w),
    .instr_signals(instr_signals_w)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] pc;
    logic [31:0] npc;
    logic [31:0] np4;
    logic [31:0] pc_w;
    logic [31:0] npc_w;
    logic [31:0] np4_w;
    logic [19:0] sig;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Architectural model state
  logic [31:0] pc_m, npc_m, pcw_m, npcw_m;

  // Reference decoder written from the field rules, one mnemonic class at a time.
  function automatic logic [19:0] ref_decode(input logic [31:0] i);
    int unsigned op, op2, op3;
    bit jmpl, call, load, rfw, se, rw, men, cce, store, branch;
    bit [1:0] size;
    bit [3:0] alu;
    op  = i[31:30];
    op2 = i[24:22];
    op3 = i[24:19];
    {jmpl, call, load, rfw, se, rw, men, cce, store, branch} = '0;
    size = 2'd0;
    alu  = 4'd0;
    case (op)
      1: begin call = 1; rfw = 1; end
      0: begin
        if (op2 == 4) begin rfw = 1; alu = 4'd14; end
        else if (op2 == 2) branch = 1;
      end
      2: begin
        if (op3 == 56) begin jmpl = 1; rfw = 1; end
        else if (op3 == 37) begin rfw = 1; alu = 4'd10; end
        else if (op3 == 38) begin rfw = 1; alu = 4'd11; end
        else if (op3 == 39) begin rfw = 1; alu = 4'd13; end
        else if (op3 < 32) begin
          rfw = 1;
          alu = 4'(op3 % 16);
          cce = (op3 >= 16);
        end
      end
      default: begin
        men  = 1;
        size = (op3 % 4 == 3) ? 2'd0 : 2'(op3 % 4);
        if ((op3 / 4) % 2 == 1) begin store = 1; rw = 1; end
        else begin load = 1; rfw = 1; se = ((op3 / 8) % 2 == 1); end
      end
    endcase
    return {branch, store, alu, i[13], i[24], i[30], i[31], cce, size, men, rw, se, rfw,
            load, call, jmpl};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every cycle is a valid observation once an expectation is queued.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("pc", pc, e.pc);
      chk("npc", npc, e.npc);
      chk("npc_plus4", npc_plus4, e.np4);
      chk("instr_signals", {12'd0, instr_signals}, {12'd0, e.sig});
      chk("pc_wrap", pc_w, e.pc_w);
      chk("npc_wrap", npc_w, e.npc_w);
      chk("npc_plus4_wrap", npc_plus4_w, e.np4_w);
    end
  end

  // Drive one cycle of inputs, queue what the monitor should see this cycle,
  // then advance the model across the coming edge.
  task automatic step(input logic c, input logic l, input logic [31:0] ins,
                      input logic [19:0] sig_exp);
    exp_t e;
    @(posedge clk);
    #1;
    clr   = c;
    le    = l;
    instr = ins;
    e.pc    = pc_m;
    e.npc   = npc_m;
    e.np4   = npc_m + 32'd4;
    e.pc_w  = pcw_m;
    e.npc_w = npcw_m;
    e.np4_w = npcw_m + 32'd4;
    e.sig   = sig_exp;
    q.push_back(e);
    if (c) begin
      pc_m   = 32'd0;
      npc_m  = 32'd4;
      pcw_m  = WrapReset;
      npcw_m = WrapReset + 32'd4;
    end else if (l) begin
      pc_m   = npc_m;
      npc_m  = npc_m + 32'd4;
      pcw_m  = npcw_m;
      npcw_m = npcw_m + 32'd4;
    end
  endtask

  logic [31:0] ri;
  int unsigned op3_pick[8] = '{37, 38, 39, 56, 16, 2, 9, 5};

  initial begin
    clr   = 1'b1;
    le    = 1'b0;
    instr = 32'd0;
    @(posedge clk);
    #1;
    pc_m   = 32'd0;
    npc_m  = 32'd4;
    pcw_m  = WrapReset;
    npcw_m = WrapReset + 32'd4;

    // Directed: run, hold at pc=8, resume, mid-run reset at pc=20; known decodes.
    step(1'b0, 1'b1, 32'h8680_4002, 20'h00608);  // addcc
    step(1'b0, 1'b1, 32'hC248_0000, 20'h00CDC);  // ldsb
    step(1'b0, 1'b0, 32'hC228_0000, 20'h40CE0);  // stb
    step(1'b0, 1'b0, 32'h4000_0004, 20'h0080A);  // call
    step(1'b0, 1'b0, 32'h1080_0002, 20'h80000);  // ba
    step(1'b0, 1'b1, 32'h81C3_E008, 20'h03409);  // jmpl
    step(1'b0, 1'b1, 32'h0000_0000, 20'h00000);
    step(1'b0, 1'b1, 32'h0300_0001, ref_decode(32'h0300_0001));  // sethi
    step(1'b1, 1'b1, 32'h8128_6002, ref_decode(32'h8128_6002));  // sll, clr over le
    step(1'b0, 1'b1, 32'h8130_6002, ref_decode(32'h8130_6002));  // srl
    step(1'b0, 1'b1, 32'h8138_6002, ref_decode(32'h8138_6002));  // sra

    // Randomized phase
    for (int n = 0; n < 400; n++) begin
      logic c, l;
      ri = $urandom;
      if ($urandom_range(1, 0) == 1) ri[24:19] = 6'(op3_pick[$urandom_range(7, 0)]);
      c = ($urandom_range(19, 0) == 0);
      l = ($urandom_range(3, 0) != 0);
      step(c, l, ri, ref_decode(ri));
    end

    for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
